uart_tx_arbiter: RTL

// Round-robin packet arbiter that shares the single UART Tx FIFO write port among NUM_REQ byte-stream requesters.

---
 rtl/uart_tx_arbiter_pkg.sv | 20 ++
 rtl/uart_tx_arbiter_if.sv | 27 ++
 rtl/rr_priority_pick.sv | 28 ++
 rtl/uart_tx_arbiter.sv | 125 ++++++++++++
 4 files changed

// File: rtl/uart_tx_arbiter_pkg.sv
// Shared constants and types for the UART Tx packet arbiter.
package uart_tx_arbiter_pkg;

  localparam int UART_DATA_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ARB  = 2'd1,
    ST_XFER = 2'd2
  } arb_state_e;

  // Ceiling log2, usable in parameter expressions.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) result++;
    return result;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester byte streams plus the Tx FIFO write port, as seen by the arbiter (master) and its environment (slave).
interface uart_tx_arbiter_if
  import uart_tx_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = UART_DATA_W
);

  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        req_last;
  logic [NUM_REQ-1:0]        req_ready;
  logic                      tx_fifo_full;
  logic                      tx_fifo_wr_en;
  logic [DATA_W-1:0]         tx_fifo_din;

  modport master (
    input  req_valid, req_data, req_last, tx_fifo_full,
    output req_ready, tx_fifo_wr_en, tx_fifo_din
  );

  modport slave (
    output req_valid, req_data, req_last, tx_fifo_full,
    input  req_ready, tx_fifo_wr_en, tx_fifo_din
  );

endinterface

// File: rtl/rr_priority_pick.sv
// Round-robin pick: lowest set request at or above ptr_i, otherwise wrap to the lowest set request overall.
module rr_priority_pick #(
  parameter int NUM_REQ = 4,
  parameter int IDW     = 2
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDW-1:0]     ptr_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic               valid_o
);

  logic [NUM_REQ-1:0] at_or_above_ptr;
  logic [NUM_REQ-1:0] masked_req;

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_mask
      assign at_or_above_ptr[gi] = (IDW'(gi) >= ptr_i);
    end
  endgenerate

  assign masked_req = req_i & at_or_above_ptr;
  assign valid_o    = |req_i;

  // x & (~x + 1) isolates the lowest set bit.
  assign gnt_o = (|masked_req) ? (masked_req & (~masked_req + NUM_REQ'(1)))
                               : (req_i & (~req_i + NUM_REQ'(1)));

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin packet arbiter sharing the UART Tx FIFO write port among NUM_REQ byte streams.
// A grant is held until the grantee writes its last byte or MAX_PKT bytes, so packets never interleave.
module uart_tx_arbiter
  import uart_tx_arbiter_pkg::*;
#(
  parameter int  NUM_REQ = 4,
  parameter int  DATA_W  = UART_DATA_W,
  parameter int  MAX_PKT = 16,
  localparam int IDW     = clog2(NUM_REQ),
  localparam int CNT_W   = clog2(MAX_PKT + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              locked_i,
  uart_tx_arbiter_if.master bus,
  output logic [IDW-1:0]    grant_id_o,
  output logic              busy_o,
  output logic              cut_pulse_o
);

  arb_state_e         state_q;
  logic [IDW-1:0]     rr_ptr_q;
  logic [IDW-1:0]     grant_q;
  logic [CNT_W-1:0]   byte_cnt_q;
  logic               busy_q;
  logic               cut_q;

  logic [NUM_REQ-1:0] pick_onehot;
  logic               pick_valid;
  logic [IDW-1:0]     pick_idx;
  logic [IDW-1:0]     next_ptr;
  logic [DATA_W-1:0]  req_byte [NUM_REQ];
  logic [NUM_REQ-1:0] ready_vec;
  logic               can_write;
  logic               wr_en;

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      assign req_byte[gi] = bus.req_data[gi*DATA_W +: DATA_W];
    end
  endgenerate

  rr_priority_pick #(
    .NUM_REQ (NUM_REQ),
    .IDW     (IDW)
  ) u_pick (
    .req_i   (bus.req_valid),
    .ptr_i   (rr_ptr_q),
    .gnt_o   (pick_onehot),
    .valid_o (pick_valid)
  );

  always_comb begin
    pick_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick_onehot[i]) pick_idx = IDW'(i);
    end
  end

  // A lost clock lock stalls the grantee exactly like a full FIFO.
  assign can_write = (state_q == ST_XFER) && locked_i && !bus.tx_fifo_full;
  assign wr_en     = can_write && bus.req_valid[grant_q];
  assign next_ptr  = (grant_q == IDW'(NUM_REQ - 1)) ? '0 : grant_q + 1'b1;

  always_comb begin
    ready_vec = '0;
    if (can_write) ready_vec[grant_q] = 1'b1;
  end

  assign bus.req_ready     = ready_vec;
  assign bus.tx_fifo_wr_en = wr_en;
  assign bus.tx_fifo_din   = wr_en ? req_byte[grant_q] : '0;
  assign grant_id_o        = grant_q;
  assign busy_o            = busy_q;
  assign cut_pulse_o       = cut_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      rr_ptr_q   <= '0;
      grant_q    <= '0;
      byte_cnt_q <= '0;
      busy_q     <= 1'b0;
      cut_q      <= 1'b0;
    end else begin
      cut_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (locked_i) state_q <= ST_ARB;
        end
        ST_ARB: begin
          if (!locked_i) begin
            state_q <= ST_IDLE;
          end else if (pick_valid) begin
            grant_q    <= pick_idx;
            byte_cnt_q <= '0;
            busy_q     <= 1'b1;
            state_q    <= ST_XFER;
          end
        end
        ST_XFER: begin
          if (wr_en) begin
            byte_cnt_q <= byte_cnt_q + 1'b1;
            // req_last takes precedence over the length cut, so no cut pulse then.
            if (bus.req_last[grant_q]) begin
              rr_ptr_q <= next_ptr;
              busy_q   <= 1'b0;
              state_q  <= ST_ARB;
            end else if (byte_cnt_q == CNT_W'(MAX_PKT - 1)) begin
              rr_ptr_q <= next_ptr;
              busy_q   <= 1'b0;
              cut_q    <= 1'b1;
              state_q  <= ST_ARB;
            end
          end
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
